// File: rtl/norm_row_sched.sv
// norm_row_sched: issues one RMSNorm engine command per row of a job,
// with strided src/dst bases, a per-row watchdog, abort and fault status.
// Ports:
//   clk, rst                  : clock, sync active-high reset
//   job_valid/job_ready       : job handshake (ready only in IDLE)
//   job_rows/job_length       : row count and hidden dimension
//   job_*_base, job_*_stride  : row-0 addresses and per-row increments
//   abort                     : one-cycle early-stop request
//   eng_cmd_valid/eng_cmd_ready, eng_length/eng_*_base : engine command
//   eng_done                  : engine row-complete pulse
//   busy, done, rows_done     : job progress
//   err_len, err_timeout, aborted : sticky job status
module norm_row_sched #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [15:0] job_rows,
  input  logic [15:0] job_length,
  input  logic [15:0] job_src_base,
  input  logic [15:0] job_dst_base,
  input  logic [15:0] job_gamma_base,
  input  logic [15:0] job_src_stride,
  input  logic [15:0] job_dst_stride,
  input  logic        abort,
  output logic        eng_cmd_valid,
  input  logic        eng_cmd_ready,
  output logic [15:0] eng_length,
  output logic [15:0] eng_src_base,
  output logic [15:0] eng_dst_base,
  output logic [15:0] eng_gamma_base,
  input  logic        eng_done,
  output logic        busy,
  output logic        done,
  output logic [15:0] rows_done,
  output logic        err_len,
  output logic        err_timeout,
  output logic        aborted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FIN
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_rows;
  logic [15:0] r_length;
  logic [15:0] r_gamma;
  logic [15:0] r_src_stride;
  logic [15:0] r_dst_stride;
  logic [15:0] r_cur_src;
  logic [15:0] r_cur_dst;
  logic [15:0] r_rows_done;
  logic        r_err_len;
  logic        r_err_timeout;
  logic        r_aborted;
  logic        r_abort_pend;
  logic [31:0] r_wdog;

  logic [15:0] w_rows_inc;
  logic        w_abort_now;
  logic        w_last;
  logic        w_expire;

  assign w_rows_inc  = r_rows_done + 16'd1;
  // abort in the current cycle counts as if it were already pending
  assign w_abort_now = r_abort_pend | abort;
  assign w_last      = (w_rows_inc == r_rows);
  assign w_expire    = (TIMEOUT_CYCLES != 32'd0) &&
                       (r_wdog == TIMEOUT_CYCLES - 32'd1);

  assign eng_length     = r_length;
  assign eng_src_base   = r_cur_src;
  assign eng_dst_base   = r_cur_dst;
  assign eng_gamma_base = r_gamma;
  assign rows_done      = r_rows_done;
  assign err_len        = r_err_len;
  assign err_timeout    = r_err_timeout;
  assign aborted        = r_aborted;

  always_comb begin
    w_state_nxt   = r_state;
    job_ready     = 1'b0;
    eng_cmd_valid = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        job_ready = 1'b1;
        busy      = 1'b0;
        if (job_valid) begin
          if (job_rows == 16'd0 || job_length == 16'd0)
            w_state_nxt = S_FIN;
          else
            w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // an abort withdraws the command before any handshake
        if (w_abort_now) begin
          w_state_nxt = S_FIN;
        end else begin
          eng_cmd_valid = 1'b1;
          if (eng_cmd_ready)
            w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // eng_done takes priority over a simultaneous watchdog expiry
        if (eng_done) begin
          if (w_last || w_abort_now)
            w_state_nxt = S_FIN;
          else
            w_state_nxt = S_ISSUE;
        end else if (w_expire) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_rows        <= 16'd0;
      r_length      <= 16'd0;
      r_gamma       <= 16'd0;
      r_src_stride  <= 16'd0;
      r_dst_stride  <= 16'd0;
      r_cur_src     <= 16'd0;
      r_cur_dst     <= 16'd0;
      r_rows_done   <= 16'd0;
      r_err_len     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_aborted     <= 1'b0;
      r_abort_pend  <= 1'b0;
      r_wdog        <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        S_IDLE: begin
          if (job_valid) begin
            r_rows        <= job_rows;
            r_length      <= job_length;
            r_gamma       <= job_gamma_base;
            r_src_stride  <= job_src_stride;
            r_dst_stride  <= job_dst_stride;
            r_cur_src     <= job_src_base;
            r_cur_dst     <= job_dst_base;
            r_rows_done   <= 16'd0;
            r_err_timeout <= 1'b0;
            r_aborted     <= 1'b0;
            r_abort_pend  <= 1'b0;
            r_err_len     <= (job_rows != 16'd0) &&
                             (job_length == 16'd0);
          end
        end
        S_ISSUE: begin
          if (abort)
            r_abort_pend <= 1'b1;
          if (w_abort_now)
            r_aborted <= 1'b1;
          else if (eng_cmd_ready)
            r_wdog <= 32'd0;
        end
        S_WAIT: begin
          if (abort)
            r_abort_pend <= 1'b1;
          if (eng_done) begin
            r_rows_done <= w_rows_inc;
            r_cur_src   <= r_cur_src + r_src_stride;
            r_cur_dst   <= r_cur_dst + r_dst_stride;
            if (w_abort_now && !w_last)
              r_aborted <= 1'b1;
          end else if (w_expire) begin
            r_err_timeout <= 1'b1;
          end else begin
            r_wdog <= r_wdog + 32'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_norm_row_sched.sv
// tb_norm_row_sched: directed bench for norm_row_sched with a command
// scoreboard; a second instance with a short watchdog covers timeouts.
module tb_norm_row_sched;

  typedef struct packed {
    logic [15:0] len;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] gamma;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid;
  logic        t_job_valid;
  logic [15:0] job_rows, job_length;
  logic [15:0] job_src_base, job_dst_base, job_gamma_base;
  logic [15:0] job_src_stride, job_dst_stride;
  logic        abort;
  logic        eng_cmd_ready;
  logic        eng_done;

  logic        job_ready, eng_cmd_valid, busy, done;
  logic [15:0] eng_length, eng_src_base, eng_dst_base, eng_gamma_base;
  logic [15:0] rows_done;
  logic        err_len, err_timeout, aborted;

  logic        t_job_ready, t_eng_cmd_valid, t_busy, t_done;
  logic [15:0] t_eng_length, t_eng_src_base, t_eng_dst_base;
  logic [15:0] t_eng_gamma_base, t_rows_done;
  logic        t_err_len, t_err_timeout, t_aborted;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  int n_hs = 0;
  int d0, h0;
  cmd_t sb[$];

  always #5 clk = ~clk;

  norm_row_sched dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_rows(job_rows), .job_length(job_length),
    .job_src_base(job_src_base), .job_dst_base(job_dst_base),
    .job_gamma_base(job_gamma_base),
    .job_src_stride(job_src_stride), .job_dst_stride(job_dst_stride),
    .abort(abort),
    .eng_cmd_valid(eng_cmd_valid), .eng_cmd_ready(eng_cmd_ready),
    .eng_length(eng_length), .eng_src_base(eng_src_base),
    .eng_dst_base(eng_dst_base), .eng_gamma_base(eng_gamma_base),
    .eng_done(eng_done), .busy(busy), .done(done),
    .rows_done(rows_done), .err_len(err_len),
    .err_timeout(err_timeout), .aborted(aborted)
  );

  norm_row_sched #(.TIMEOUT_CYCLES(32'd16)) dut_to (
    .clk(clk), .rst(rst),
    .job_valid(t_job_valid), .job_ready(t_job_ready),
    .job_rows(job_rows), .job_length(job_length),
    .job_src_base(job_src_base), .job_dst_base(job_dst_base),
    .job_gamma_base(job_gamma_base),
    .job_src_stride(job_src_stride), .job_dst_stride(job_dst_stride),
    .abort(abort),
    .eng_cmd_valid(t_eng_cmd_valid), .eng_cmd_ready(eng_cmd_ready),
    .eng_length(t_eng_length), .eng_src_base(t_eng_src_base),
    .eng_dst_base(t_eng_dst_base), .eng_gamma_base(t_eng_gamma_base),
    .eng_done(eng_done), .busy(t_busy), .done(t_done),
    .rows_done(t_rows_done), .err_len(t_err_len),
    .err_timeout(t_err_timeout), .aborted(t_aborted)
  );

  always @(negedge clk) begin
    #1;
    if (done) n_done++;
    if (eng_cmd_valid && eng_cmd_ready) n_hs++;
  end

  task automatic chk(input string tag, input logic [79:0] obs,
                     input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_ctl"},
        {job_ready, busy, eng_cmd_valid, done,
         err_len, err_timeout, aborted}, 80'b1000000);
    chk({tag, "_fld"},
        {eng_length, eng_src_base, eng_dst_base, eng_gamma_base},
        80'd0);
    chk({tag, "_rows"}, rows_done, 80'd0);
  endtask

  task automatic push_job(input int rows, input logic [15:0] len,
                          input logic [15:0] src, input logic [15:0] ss,
                          input logic [15:0] dst, input logic [15:0] ds,
                          input logic [15:0] g, input int n_push);
    cmd_t c;
    job_rows = 16'(rows);
    job_length = len;
    job_src_base = src;
    job_src_stride = ss;
    job_dst_base = dst;
    job_dst_stride = ds;
    job_gamma_base = g;
    for (int i = 0; i < n_push; i++) begin
      c.len = len;
      c.src = src + 16'(i) * ss;
      c.dst = dst + 16'(i) * ds;
      c.gamma = g;
      sb.push_back(c);
    end
  endtask

  // Serve one engine command: optional backpressure, scoreboard check,
  // done after lat cycles, optional abort at WAIT cycle ab_at.
  task automatic serve(input string tag, input int lat, input int bp,
                       input int bp_next, input int ab_at);
    cmd_t e;
    for (int i = 0; i < 200 && !eng_cmd_valid; i++) begin
      @(negedge clk);
      #1;
    end
    chk({tag, "_vld"}, eng_cmd_valid, 80'd1);
    e = (sb.size() != 0) ? sb[0] : '0;
    for (int i = 0; i < bp; i++) begin
      chk({tag, "_bp"},
          {eng_cmd_valid, eng_cmd_ready, eng_length, eng_src_base,
           eng_dst_base, eng_gamma_base}, {2'b10, e});
      @(negedge clk);
    end
    eng_cmd_ready = 1'b1;
    #1;
    chk({tag, "_sbq"}, (sb.size() != 0), 80'd1);
    if (sb.size() != 0) e = sb.pop_front();
    chk({tag, "_cmd"},
        {eng_length, eng_src_base, eng_dst_base, eng_gamma_base}, e);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      abort = (i == ab_at);
      eng_done = (i == lat);
    end
    @(negedge clk);
    abort = 1'b0;
    eng_done = 1'b0;
    eng_cmd_ready = (bp_next == 0);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=stuck expected=finish");
    $fatal(1, "bench stuck");
  end

  initial begin
    rst = 1'b1;
    job_valid = 1'b0;
    t_job_valid = 1'b0;
    abort = 1'b0;
    eng_cmd_ready = 1'b1;
    eng_done = 1'b0;
    push_job(0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_rst("reset");

    // strided job, 3 rows, engine latency 70
    @(negedge clk);
    d0 = n_done;
    h0 = n_hs;
    push_job(3, 16'd64, 16'h0100, 16'h0040, 16'h0400, 16'h0040,
             16'h0020, 3);
    job_valid = 1'b1;
    #1;
    chk("t1_ready", job_ready, 80'd1);
    @(negedge clk);
    job_valid = 1'b0;
    #1;
    chk("t1_lat", eng_cmd_valid, 80'd1);
    serve("t1r0", 70, 0, 0, 0);
    chk("t1_next0", eng_cmd_valid, 80'd1);
    serve("t1r1", 70, 0, 0, 0);
    chk("t1_next1", eng_cmd_valid, 80'd1);
    serve("t1r2", 70, 0, 0, 0);
    chk("t1_fin", {done, rows_done}, {1'b1, 16'd3});
    @(negedge clk);
    #1;
    chk("t1_idle", {job_ready, done}, 80'b10);
    chk("t1_flags", {err_len, err_timeout, aborted}, 80'd0);
    @(negedge clk);
    chk("t1_ndone", n_done - d0, 80'd1);
    chk("t1_nhs", n_hs - h0, 80'd3);

    // zero-row job
    d0 = n_done;
    h0 = n_hs;
    push_job(0, 16'd5, 16'h10, 16'h1, 16'h20, 16'h1, 16'h3, 0);
    job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    #1;
    chk("t2_zero_done", {done, eng_cmd_valid, err_len}, 80'b100);
    @(negedge clk);
    #1;
    chk("t2_zero_idle", job_ready, 80'd1);

    // zero-length job is rejected
    @(negedge clk);
    push_job(4, 16'd0, 16'h10, 16'h1, 16'h20, 16'h1, 16'h3, 0);
    job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    #1;
    chk("t2_len_done", {done, eng_cmd_valid, err_len}, 80'b101);
    @(negedge clk);
    #1;
    chk("t2_len_sticky", {job_ready, err_len, rows_done},
        {2'b11, 16'd0});
    @(negedge clk);
    chk("t2_nhs", n_hs - h0, 80'd0);
    chk("t2_ndone", n_done - d0, 80'd2);

    // backpressure on row 1 and src address wrap
    push_job(2, 16'd8, 16'hFFC0, 16'h0040, 16'h1000, 16'h0010,
             16'h0033, 2);
    job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    #1;
    serve("t3r0", 5, 0, 5, 0);
    serve("t3r1", 5, 5, 0, 0);
    chk("t3_fin", {done, rows_done, err_len}, {1'b1, 16'd2, 1'b0});

    // abort during WAIT of row 1 of 4
    @(negedge clk);
    d0 = n_done;
    h0 = n_hs;
    push_job(4, 16'd16, 16'h0200, 16'h0010, 16'h0300, 16'h0010,
             16'h0040, 2);
    job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    #1;
    serve("t4r0", 4, 0, 0, 0);
    serve("t4r1", 6, 0, 0, 2);
    chk("t4_fin", {done, rows_done, aborted, eng_cmd_valid},
        {1'b1, 16'd2, 1'b1, 1'b0});
    @(negedge clk);
    #1;
    chk("t4_idle", {job_ready, eng_cmd_valid}, 80'b10);
    @(negedge clk);
    chk("t4_nhs", n_hs - h0, 80'd2);
    chk("t4_ndone", n_done - d0, 80'd1);

    // abort during ISSUE under backpressure
    h0 = n_hs;
    eng_cmd_ready = 1'b0;
    push_job(2, 16'd8, 16'h0A00, 16'h1, 16'h0B00, 16'h1, 16'h1, 0);
    job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    #1;
    chk("t5_vld", eng_cmd_valid, 80'd1);
    @(negedge clk);
    abort = 1'b1;
    #1;
    chk("t5_withdraw", eng_cmd_valid, 80'd0);
    @(negedge clk);
    abort = 1'b0;
    eng_cmd_ready = 1'b1;
    #1;
    chk("t5_fin", {done, aborted, rows_done, eng_cmd_valid},
        {1'b1, 1'b1, 16'd0, 1'b0});
    @(negedge clk);
    chk("t5_nhs", n_hs - h0, 80'd0);

    // watchdog expiry, TIMEOUT_CYCLES=16
    push_job(1, 16'd8, 16'h0500, 16'h1, 16'h0510, 16'h1, 16'h2, 0);
    t_job_valid = 1'b1;
    @(negedge clk);
    t_job_valid = 1'b0;
    #1;
    chk("t6_hs", t_eng_cmd_valid, 80'd1);
    repeat (16) @(negedge clk);
    #1;
    chk("t6_pre", {t_done, t_err_timeout}, 80'b00);
    @(negedge clk);
    #1;
    chk("t6_fin", {t_done, t_err_timeout, t_busy, t_rows_done},
        {3'b111, 16'd0});
    @(negedge clk);
    #1;
    chk("t6_sticky", {t_job_ready, t_err_timeout}, 80'b11);

    // eng_done on the expiry cycle wins
    @(negedge clk);
    push_job(2, 16'd8, 16'h0600, 16'h0020, 16'h0700, 16'h1, 16'h2, 0);
    t_job_valid = 1'b1;
    @(negedge clk);
    t_job_valid = 1'b0;
    #1;
    chk("t7_hs", t_eng_cmd_valid, 80'd1);
    repeat (16) @(negedge clk);
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    #1;
    chk("t7_row", {t_err_timeout, t_done, t_eng_cmd_valid,
                   t_rows_done, t_eng_src_base},
        {3'b001, 16'd1, 16'h0620});
    repeat (3) @(negedge clk);
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    #1;
    chk("t7_fin", {t_done, t_err_timeout, t_rows_done},
        {2'b10, 16'd2});

    // reset asserted mid-WAIT
    @(negedge clk);
    push_job(3, 16'd8, 16'h0700, 16'h8, 16'h0800, 16'h8, 16'h9, 3);
    job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    #1;
    serve("t8r0", 3, 0, 0, 0);
    chk("t8_rows1", rows_done, 80'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_rst("t8_rst");
    sb.delete();
    @(negedge clk);
    d0 = n_done;
    h0 = n_hs;
    repeat (3) @(negedge clk);
    chk("t8_quiet", {n_done - d0, n_hs - h0}, 80'd0);
    push_job(1, 16'd12, 16'h0C00, 16'h4, 16'h0D00, 16'h4, 16'h5, 1);
    job_valid = 1'b1;
    #1;
    chk("t8_ready", job_ready, 80'd1);
    @(negedge clk);
    job_valid = 1'b0;
    #1;
    serve("t8n0", 5, 0, 0, 0);
    chk("t8_fin", {done, rows_done, aborted}, {1'b1, 16'd1, 1'b0});
    @(negedge clk);
    chk("t8_sb_empty", sb.size(), 80'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/norm_row_sched.md
# norm_row_sched

Row scheduler for the RMSNorm engine. It accepts one multi-row normalization job, such as a full token batch, and issues one engine command per row. Each command carries strided source and destination bases and a shared gamma base. The scheduler waits for each row's completion pulse and reports job completion, abort and fault status. It sits between the NPU command decoder and the engine's command/status interface, and it owns that interface exclusively.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 32'd65536: per-row watchdog limit in cycles; 0 disables the watchdog.

Ports:
- clk  in  1  Single clock; all logic is on the rising edge.
- rst  in  1  Reset, synchronous and active-high.
- job_valid  in  1  A job request is present.
- job_ready  out  1  Scheduler can accept a job (high only in IDLE).
- job_rows  in  16  Number of rows to normalize.
- job_length  in  16  Hidden dimension per row.
- job_src_base / job_dst_base / job_gamma_base  in  16 each  Row-0 input address, row-0 output address, gamma address.
- job_src_stride / job_dst_stride  in  16 each  Address increment per row.
- abort  in  1  Single-cycle request to stop the job early.
- eng_cmd_valid  out  1  Command to the engine.
- eng_cmd_ready  in  1  Engine is accepting a command.
- eng_length / eng_src_base / eng_dst_base / eng_gamma_base  out  16 each  Command fields for the engine.
- eng_done  in  1  Engine row-complete pulse.
- busy  out  1  Scheduler is not in IDLE.
- done  out  1  One-cycle pulse at job end, including rejected, aborted and timed-out jobs.
- rows_done  out  16  Count of rows completed in the current or last job.
- err_len  out  1  Sticky flag: a job with length 0 and rows ≠ 0 was rejected.
- err_timeout  out  1  Sticky flag: the watchdog expired.
- aborted  out  1  Sticky flag: the last job ended because of abort.

## Operation
- States are IDLE, ISSUE, WAIT and FIN.
- **IDLE:** job_ready=1. When job_valid=1:
  - Latch all job fields.
  - Clear rows_done, err_len, err_timeout, aborted and abort_pending.
  - Set cur_src=job_src_base and cur_dst=job_dst_base.
  - If job_rows==0, go to FIN.
  - Else if job_length==0, set err_len and go to FIN. The engine must never see length 0.
  - Else go to ISSUE.
- **ISSUE:** eng_cmd_valid=1.
  - Command fields are latched length, cur_src, cur_dst and latched gamma base. They stay stable while valid=1 and ready=0.
  - On the handshake cycle (valid & ready), go to WAIT and clear the watchdog.
  - If abort_pending or abort is seen before the handshake, withdraw valid and go to FIN with aborted=1. No command is issued.
- **WAIT:** eng_cmd_valid=0.
  - On eng_done:
    - Increment rows_done.
    - Advance cur_src += src_stride and cur_dst += dst_stride, modulo 2^16 with silent wrap.
    - If rows_done+1 == rows, or abort_pending is set (including abort in this same cycle), go to FIN. Set aborted only if rows remain.
    - Otherwise go to ISSUE.
  - Without eng_done: increment the watchdog. If TIMEOUT_CYCLES≠0 and the watchdog == TIMEOUT_CYCLES-1, set err_timeout and go to FIN.
  - If eng_done and watchdog expiry occur in the same cycle, eng_done wins.
- **FIN:** done=1 for one cycle, then go to IDLE.
- **abort handling:** abort is sampled in ISSUE and WAIT and sets abort_pending. It is ignored in IDLE and FIN.
- **Watchdog:** 32-bit counter.
- **Status hold:** rows_done and the sticky flags hold after the job until the next job is accepted.

## Timing
- Reset values:
  - State IDLE.
  - job_ready=1 and busy=0.
  - eng_cmd_valid=0 and done=0.
  - rows_done=0; err_len, err_timeout and aborted all 0.
  - eng_* address and length fields 0.
- Reset asserted mid-job returns to IDLE on the next edge. No further command is issued and done does not pulse.
- Job accepted at cycle T: eng_cmd_valid is high from T+1.
- Zero-row or rejected job accepted at T: done pulses at T+1 and no command is issued.
- eng_done at cycle D with rows remaining: the next command's valid is high at D+1. The engine is back in IDLE by then, so the handshake occurs at D+1.
- Last eng_done at cycle D: done pulses at D+1 and job_ready is high at D+2.
- Per-row overhead between the engine finishing and receiving the next command is 1 cycle.

## Test plan
- **Strided job:**
  - Stimulus: rows=3, length=64, src=0x0100, src_stride=0x40, dst=0x0400, dst_stride=0x40, gamma=0x0020. Engine model: ready always high, done 70 cycles after each command.
  - Response: commands with src 0x100/0x140/0x180 and dst 0x400/0x440/0x480, all with gamma 0x20. Exactly one done pulse; rows_done=3; no flags set.
- **Degenerate jobs:**
  - rows=0: done at T+1, no eng_cmd_valid.
  - rows=4, length=0: done at T+1, err_len=1, no command.
- **Backpressure and wrap:**
  - Stimulus: eng_cmd_ready held low for 5 cycles on row 1; src=0xFFC0 with stride 0x40.
  - Response: valid held with stable fields for 5 cycles. The row-1 command has src=0x0000 (wrap).
- **Abort:**
  - Abort during WAIT of row 1 of 4: that row completes, then done with rows_done=2 and aborted=1. No row-2 command.
  - Abort during ISSUE: valid drops and done follows next cycle.
- **Timeout:**
  - Stimulus: TIMEOUT_CYCLES=16, engine never pulses done.
  - Response: err_timeout=1 and FIN entered 16 cycles after the handshake; done pulses.
  - Stimulus: eng_done exactly on the expiry cycle. Response: the row counts and err_timeout=0.
- **Reset mid-WAIT:**
  - Stimulus: rst asserted for 1 cycle.
  - Response: next cycle all outputs are at reset values. A new job is accepted normally afterwards.
